// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC converting (x, y) into atan2 angle and magnitude.
// Optional magnitude gain compensation is enabled by defining CORDIC_VECTOR_GAIN_COMP_EN.
module cordic_vector #(
  parameter int ITER = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] angle_out,
  output logic        [31:0] mag_out
);

  localparam logic signed [31:0] HALF_PI_POS = 32'sh3243F6A9;
  localparam logic signed [31:0] HALF_PI_NEG = 32'shCDBC0957;
  localparam logic        [4:0]  LAST_CNT    = 5'(ITER - 1);

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam logic [31:0] GAIN_K = 32'h26DD3B6A;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    SCALE,
    FINISH
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    FINISH
  } state_t;
`endif

  state_t state, next_state;

  logic signed [33:0] x, y;
  logic signed [31:0] z;
  logic        [4:0]  cnt;
  logic               zero_flag;
  logic               load, step, finish;
  logic signed [33:0] x_ext_in, y_ext_in;
  logic        [31:0] mag_sel;

  // atan(2^-i) in Q3.29; from i = 11 on the arctangent equals 2^-i to within rounding
  function automatic logic signed [31:0] beta_lut(input logic [4:0] i);
    case (i)
      5'd0:    beta_lut = 32'sh1921FB54;
      5'd1:    beta_lut = 32'sh0ED63383;
      5'd2:    beta_lut = 32'sh07D6DD7E;
      5'd3:    beta_lut = 32'sh03FAB753;
      5'd4:    beta_lut = 32'sh01FF55BB;
      5'd5:    beta_lut = 32'sh00FFEAAE;
      5'd6:    beta_lut = 32'sh007FFD55;
      5'd7:    beta_lut = 32'sh003FFFAB;
      5'd8:    beta_lut = 32'sh001FFFF5;
      5'd9:    beta_lut = 32'sh000FFFFF;
      5'd10:   beta_lut = 32'sh00080000;
      default: beta_lut = (i >= 5'd30) ? 32'sd0 : (32'sd1 <<< (5'd29 - i));
    endcase
  endfunction

  assign x_ext_in = {{2{x_in[31]}}, x_in};
  assign y_ext_in = {{2{y_in[31]}}, y_in};

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  logic [65:0] prod_full;
  logic [31:0] mag_scaled;

  // Operands are extended to the full product width, so the unsigned modular
  // product carries the same low bits as the signed 34x32 product.
  assign prod_full = {{32{x[33]}}, x} * {34'd0, GAIN_K};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_scaled <= '0;
    end else if (state == SCALE) begin
      mag_scaled <= 32'(prod_full >> 30);
    end
  end

  assign mag_sel = mag_scaled;
`else
  assign mag_sel = x[31:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = ROTATE;
        end
      end
      ROTATE: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
          next_state = SCALE;
`else
          next_state = FINISH;
`endif
        end
      end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
      SCALE: begin
        next_state = FINISH;
      end
`endif
      FINISH: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Left-half-plane inputs are pre-rotated by +/-90 degrees so the micro-rotations
  // only ever have to cover the right half plane; y == 0 goes up, giving +pi.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      done <= 1'b0;

      if (load) begin
        if (!x_in[31]) begin
          x <= x_ext_in;
          y <= y_ext_in;
          z <= '0;
        end else if (!y_in[31]) begin
          x <= y_ext_in;
          y <= -x_ext_in;
          z <= HALF_PI_POS;
        end else begin
          x <= -y_ext_in;
          y <= x_ext_in;
          z <= HALF_PI_NEG;
        end
        zero_flag <= (x_in == 32'sd0) && (y_in == 32'sd0);
        cnt       <= '0;
        busy      <= 1'b1;
      end

      if (step) begin
        if (!y[33]) begin
          x <= x + (y >>> cnt);
          y <= y - (x >>> cnt);
          z <= z + beta_lut(cnt);
        end else begin
          x <= x - (y >>> cnt);
          y <= y + (x >>> cnt);
          z <= z - beta_lut(cnt);
        end
        cnt <= cnt + 5'd1;
      end

      // A zero vector has no defined angle; report a clean zero instead of the
      // accumulated micro-rotation sum.
      if (finish) begin
        angle_out <= zero_flag ? 32'sd0 : z;
        mag_out   <= zero_flag ? 32'd0 : mag_sel;
        done      <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule
